// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers, state type and MixColumns FSM encoding
package aes_pkg;

  localparam int AES_COLS = 4;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mc_state_t;

  // Multiply by x modulo the AES polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// rtl/mix_column_unit.sv - combinational MixColumns / InvMixColumns for one 32-bit column
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);

  // Row 0 sits in the top byte of the column
  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // Matrix product with the rotated {02,03,01,01} or {0e,0b,0d,09} rows
  always_comb begin
    o_col = '0;
    if (i_inv) begin
      o_col = {gf_mul14(w_a0) ^ gf_mul11(w_a1) ^ gf_mul13(w_a2) ^ gf_mul9(w_a3),
               gf_mul9(w_a0)  ^ gf_mul14(w_a1) ^ gf_mul11(w_a2) ^ gf_mul13(w_a3),
               gf_mul13(w_a0) ^ gf_mul9(w_a1)  ^ gf_mul14(w_a2) ^ gf_mul11(w_a3),
               gf_mul11(w_a0) ^ gf_mul13(w_a1) ^ gf_mul9(w_a2)  ^ gf_mul14(w_a3)};
    end else begin
      o_col = {gf_mul2(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3,
               w_a0 ^ gf_mul2(w_a1) ^ gf_mul3(w_a2) ^ w_a3,
               w_a0 ^ w_a1 ^ gf_mul2(w_a2) ^ gf_mul3(w_a3),
               gf_mul3(w_a0) ^ w_a1 ^ w_a2 ^ gf_mul2(w_a3)};
    end
  end

endmodule

// File: rtl/mix_columns_engine.sv
// rtl/mix_columns_engine.sv - sequential MixColumns engine with valid/ready on both sides
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int N  = AES_COLS / COLS_PER_CYCLE;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $fatal(1, "mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_t     r_fsm;
  logic [GW-1:0] r_grp;
  state_t        r_state;
  logic          r_inv;

  logic [1:0]    w_idx     [COLS_PER_CYCLE];
  logic [31:0]   w_col_in  [COLS_PER_CYCLE];
  logic [31:0]   w_col_out [COLS_PER_CYCLE];
  state_t        w_next_state;

  // in_ready looks at out_ready only in DONE, so a finished result can hand over in one cycle
  assign in_ready  = (r_fsm == IDLE) | ((r_fsm == DONE) & out_ready);
  assign out_valid = (r_fsm == DONE);
  assign out_state = r_state;

  // The current group selects which columns feed the column units
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign w_idx[k]    = 2'(int'(r_grp) * COLS_PER_CYCLE + k);
    assign w_col_in[k] = r_state[127 - 32*w_idx[k] -: 32];

    mix_column_unit u_mcu (
      .i_col (w_col_in[k]),
      .i_inv (r_inv),
      .o_col (w_col_out[k])
    );
  end

  // Write the transformed columns back into their original positions
  always_comb begin
    w_next_state = r_state;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_next_state[127 - 32*w_idx[k] -: 32] = w_col_out[k];
    end
  end

  // Control FSM: accept, compute one group per cycle, then hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= IDLE;
      r_grp   <= '0;
      r_state <= '0;
      r_inv   <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_inv   <= in_inv;
            r_grp   <= '0;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_next_state;
          if (r_grp == GW'(N - 1)) begin
            r_fsm <= DONE;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              r_state <= in_state;
              r_inv   <= in_inv;
              r_grp   <= '0;
              r_fsm   <= BUSY;
            end else begin
              r_fsm <= IDLE;
            end
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb/tb_mix_columns_engine.sv - self-checking bench for mix_columns_engine at 1, 2 and 4 columns per cycle
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_inv    [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [127:0] exp_q [3][$];
  int           acc_cyc  [3];
  int           acc_cnt  [3];
  int           out_cnt  [3];
  logic         prev_v   [3];
  logic         prev_hold[3];
  logic [127:0] held     [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]));

  function automatic int lat(input int d);
    return (d == 0) ? 4 : (d == 1) ? 2 : 1;
  endfunction

  // Generic shift-and-add GF(2^8) multiply, reduced by 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p  = 0;
    int aa = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
    end
    return p[7:0];
  endfunction

  // Reference: out[r][c] = sum_j coef(r,j) * in[j][c], coef row r is the base row rotated right by r
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(base[(j - r + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle checker against the queue of expected results
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        exp_q[d].delete();
        acc_cyc[d]   = -1;
        acc_cnt[d]   = 0;
        out_cnt[d]   = 0;
        prev_v[d]    = 1'b0;
        prev_hold[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        logic exp_rdy;
        exp_rdy = (exp_q[d].size() == 0) ? 1'b1 : (out_valid[d] ? out_ready[d] : 1'b0);
        chk($sformatf("in_ready[%0d]", d), 128'(in_ready[d]), 128'(exp_rdy));
        if (exp_q[d].size() == 0 && !prev_hold[d])
          chk($sformatf("idle_out_valid[%0d]", d), 128'(out_valid[d]), 128'(0));
        if (prev_hold[d]) begin
          chk($sformatf("hold_valid[%0d]", d), 128'(out_valid[d]), 128'(1));
          chk($sformatf("hold_state[%0d]", d), out_state[d], held[d]);
        end
        if (out_valid[d]) begin
          if (!prev_v[d])
            chk($sformatf("latency[%0d]", d), 128'(cyc - acc_cyc[d] - 1), 128'(lat(d)));
          if (exp_q[d].size() == 0) begin
            chk($sformatf("unexpected_result[%0d]", d), 128'(1), 128'(0));
          end else begin
            chk($sformatf("out_state[%0d]", d), out_state[d], exp_q[d][0]);
            if (out_ready[d]) begin
              void'(exp_q[d].pop_front());
              out_cnt[d]++;
            end
          end
        end
        prev_hold[d] = out_valid[d] & ~out_ready[d];
        held[d]      = out_state[d];
        prev_v[d]    = out_valid[d];
        if (in_valid[d] && in_ready[d]) begin
          exp_q[d].push_back(model(in_state[d], in_inv[d]));
          acc_cyc[d] = cyc;
          acc_cnt[d]++;
        end
      end
    end
  end

  task automatic send(input int d, input logic [127:0] s, input logic inv);
    int t = 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_state[d] = s;
    in_inv[d]   = inv;
    @(negedge clk);
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) chk($sformatf("send_timeout[%0d]", d), 128'(0), 128'(1));
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_out(input int d, input logic [127:0] exp, input string name);
    int t = 0;
    @(negedge clk);
    while (!out_valid[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[d]) chk({name, "_timeout"}, 128'(0), 128'(1));
    else               chk(name, out_state[d], exp);
  endtask

  task automatic drive_random(input int d, input int target);
    int acc = 0;
    int t   = 0;
    while (acc < target && t < 8000) begin
      @(posedge clk); #1;
      in_valid[d]  = ($urandom_range(0, 3) != 0);
      in_state[d]  = {$urandom, $urandom, $urandom, $urandom};
      in_inv[d]    = 1'($urandom_range(0, 1));
      out_ready[d] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid[d] && in_ready[d]) acc++;
      t++;
    end
    chk($sformatf("random_accepts[%0d]", d), 128'(acc), 128'(target));
    @(posedge clk); #1;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    t = 0;
    while (exp_q[d].size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk($sformatf("drain_empty[%0d]", d), 128'(exp_q[d].size()), 128'(0));
    chk($sformatf("results_vs_accepts[%0d]", d), 128'(out_cnt[d]), 128'(acc_cnt[d]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s;
    logic [127:0] s2;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_in_ready[%0d]", d),  128'(in_ready[d]),  128'(1));
      chk($sformatf("reset_out_valid[%0d]", d), 128'(out_valid[d]), 128'(0));
      chk($sformatf("reset_out_state[%0d]", d), out_state[d], 128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    chk("model_fwd", model(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0),
        128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    chk("model_inv", model(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1),
        128'hdb135345_f20a225c_01010101_c6c6c6c6);
    chk("model_fwd2", model(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0),
        128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);

    send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    wait_out(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "fwd_cpc1");
    send(1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1);
    wait_out(1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, "inv_cpc2");
    send(2, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0);
    wait_out(2, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, "fwd_cpc4");
    send(2, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 1'b1);
    wait_out(2, 128'hd4d4d4d5_2d26314c_00000000_ffffffff, "inv_cpc4");

    // Backpressure with a same-cycle handover to the next state
    s  = {$urandom, $urandom, $urandom, $urandom};
    s2 = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    send(0, s, 1'b0);
    wait_out(0, model(s, 1'b0), "bp_first");
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid[0]), 128'(1));
      chk("bp_in_ready",  128'(in_ready[0]),  128'(0));
      chk("bp_out_state", out_state[0], model(s, 1'b0));
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_state[0]  = s2;
    in_inv[0]    = 1'b1;
    @(negedge clk);
    chk("bp_handover_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("bp_no_idle_valid", 128'(out_valid[0]), 128'(0));
    chk("bp_no_idle_ready", 128'(in_ready[0]),  128'(0));
    wait_out(0, model(s2, 1'b1), "bp_second");

    // Asynchronous reset after two compute cycles
    send(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 128'(out_valid[0]), 128'(0));
    chk("rst_in_ready",  128'(in_ready[0]),  128'(1));
    chk("rst_out_state", out_state[0], 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    s = {$urandom, $urandom, $urandom, $urandom};
    send(0, s, 1'b1);
    wait_out(0, model(s, 1'b1), "post_rst");

    fork
      drive_random(0, 340);
      drive_random(1, 340);
      drive_random(2, 340);
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
